// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
// group width, stage-count helper, parameter legality check and the 4-bit CLA.
package cla_pkg;

  localparam int CLA_GROUP_W = 4;

  typedef struct packed {
    logic [3:0] sum;
    logic       gg;   // group generate
    logic       gp;   // group propagate
    logic       c3;   // carry into the group MSB
  } cla4_t;

  function automatic int cla_nseg(input int width, input int seg_w);
    return (seg_w > 32'sd0) ? (width / seg_w) : 32'sd1;
  endfunction

  function automatic bit cla_params_ok(input int width, input int seg_w);
    if (seg_w < CLA_GROUP_W) begin
      return 1'b0;
    end else begin
      return ((seg_w % CLA_GROUP_W) == 32'sd0) && (width >= seg_w) &&
             ((width % seg_w) == 32'sd0);
    end
  endfunction

  function automatic cla4_t cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    cla4_t      r;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    r.sum = p ^ c;
    r.gg  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    r.gp  = &p;
    r.c3  = c[3];
    return r;
  endfunction

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG_W-bit carry-lookahead segment built from 4-bit lookahead
// groups chained through their group generate/propagate terms.
module cla_segment
  import cla_pkg::*;
#(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b_eff,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  localparam int NGRP = SEG_W / CLA_GROUP_W;

  // group chain: each group's carry-in comes from the previous group's G/P
  always_comb begin
    logic  carry;
    cla4_t r;
    carry = cin;
    r     = cla4_t'(7'd0);
    sum   = {SEG_W{1'b0}};
    for (int j = 0; j < NGRP; j++) begin
      r = cla4(a[j*CLA_GROUP_W +: CLA_GROUP_W], b_eff[j*CLA_GROUP_W +: CLA_GROUP_W], carry);
      sum[j*CLA_GROUP_W +: CLA_GROUP_W] = r.sum;
      carry = r.gg | (r.gp & carry);
    end
    cout  = carry;
    c_msb = r.c3;
  end

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined WIDTH-bit CLA adder/subtractor: one SEG_W segment resolved per
// stage, carry registered between stages, valid/ready with a global stall.
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NSEG = cla_nseg(WIDTH, SEG_W);

  if (!cla_params_ok(WIDTH, SEG_W)) begin : g_param_check
    $error("cla_addsub_pipe: WIDTH must be a multiple of SEG_W and SEG_W a multiple of 4");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  logic [NSEG-1:0]  vld_d, vld_q;
  logic [NSEG-1:0]  c_d, c_q;
  logic [WIDTH-1:0] a_d [NSEG];
  logic [WIDTH-1:0] a_q [NSEG];
  logic [WIDTH-1:0] b_d [NSEG];
  logic [WIDTH-1:0] b_q [NSEG];
  logic [WIDTH-1:0] s_d [NSEG];
  logic [WIDTH-1:0] s_q [NSEG];
  logic             zero_d, zero_q;
  logic             ovf_d, ovf_q;

  logic [SEG_W-1:0] seg_sum [NSEG];
  logic [NSEG-1:0]  seg_cout;
  logic [NSEG-1:0]  seg_cmsb;

  assign advance = !vld_q[NSEG-1] | out_ready;
  assign b_eff   = sub ? ~b : b;
  assign c0      = cin ^ sub;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    logic [SEG_W-1:0] seg_a;
    logic [SEG_W-1:0] seg_b;
    logic             seg_ci;
    if (k == 0) begin : g_first
      assign seg_a  = a[SEG_W-1:0];
      assign seg_b  = b_eff[SEG_W-1:0];
      assign seg_ci = c0;
    end else begin : g_next
      assign seg_a  = a_q[k-1][k*SEG_W +: SEG_W];
      assign seg_b  = b_q[k-1][k*SEG_W +: SEG_W];
      assign seg_ci = c_q[k-1];
    end
    cla_segment #(.SEG_W(SEG_W)) u_seg (
      .a     (seg_a),
      .b_eff (seg_b),
      .cin   (seg_ci),
      .sum   (seg_sum[k]),
      .cout  (seg_cout[k]),
      .c_msb (seg_cmsb[k])
    );
  end

  // next stage contents: shift everything one stage and splice in this stage's segment
  always_comb begin
    vld_d[0] = in_valid;
    a_d[0]   = a;
    b_d[0]   = b_eff;
    s_d[0]   = {WIDTH{1'b0}};
    s_d[0][SEG_W-1:0] = seg_sum[0];
    c_d[0]   = seg_cout[0];
    for (int k = 1; k < NSEG; k++) begin
      vld_d[k] = vld_q[k-1];
      a_d[k]   = a_q[k-1];
      b_d[k]   = b_q[k-1];
      s_d[k]   = s_q[k-1];
      s_d[k][k*SEG_W +: SEG_W] = seg_sum[k];
      c_d[k]   = seg_cout[k];
    end
    // flags are taken from the beat entering the output register
    zero_d = (s_d[NSEG-1] == {WIDTH{1'b0}});
    ovf_d  = seg_cmsb[NSEG-1] ^ seg_cout[NSEG-1];
  end

  // stage registers; all stages hold together when the output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= {NSEG{1'b0}};
      c_q    <= {NSEG{1'b0}};
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      for (int k = 0; k < NSEG; k++) begin
        a_q[k] <= {WIDTH{1'b0}};
        b_q[k] <= {WIDTH{1'b0}};
        s_q[k] <= {WIDTH{1'b0}};
      end
    end else if (advance) begin
      vld_q  <= vld_d;
      c_q    <= c_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
      for (int k = 0; k < NSEG; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign in_ready  = advance;
  assign out_valid = vld_q[NSEG-1];
  assign sum       = s_q[NSEG-1];
  assign cout      = c_q[NSEG-1];
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Scoreboard bench for cla_addsub_pipe: directed corner beats plus randomized
// traffic with random backpressure, checked against an integer reference model.
module tb_cla_addsub_pipe;

  localparam int WIDTH = 32;
  localparam int SEG_W = 8;
  localparam int NSEG  = WIDTH / SEG_W;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        cout;
  logic        overflow;
  logic        zero;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_pop = 0;

  cla_addsub_pipe #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  // Reference: exact integer arithmetic, signed overflow from the true signed result.
  function automatic exp_t ref_model(input logic [31:0] ra, input logic [31:0] rb,
                                     input logic rc, input logic rs);
    longint ua, ub, ur, sa, sbv, sr;
    int     ia, ib;
    exp_t   e;
    ua = longint'({32'd0, ra});
    ub = longint'({32'd0, rb});
    ia = $signed(ra);
    ib = $signed(rb);
    sa = ia;
    sbv = ib;
    if (rs) begin
      ur = ua - ub - longint'(rc);
      sr = sa - sbv - longint'(rc);
      e.cout = (ur >= 64'sd0);
    end else begin
      ur = ua + ub + longint'(rc);
      sr = sa + sbv + longint'(rc);
      e.cout = ur[32];
    end
    e.sum  = ur[31:0];
    e.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.zero = (e.sum == 32'd0);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic tc, input logic ts, input logic ordy,
                       input exp_t e, output logic acc);
    @(negedge clk);
    in_valid  = v;
    a         = ta;
    b         = tb_v;
    cin       = tc;
    sub       = ts;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (acc) sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int k = 0; k < n; k++) drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, exp_t'(35'd0), acc);
  endtask

  task automatic drain(input int max_cyc);
    logic acc;
    for (int k = 0; k < max_cyc && sb_q.size() > 0; k++)
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, exp_t'(35'd0), acc);
    check("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor: compares every presented result with the oldest expectation, pops on consume.
  initial begin
    exp_t got;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_result: got sum=%h with no beat outstanding", sum);
        end else begin
          got = {sum, cout, overflow, zero};
          if (got !== sb_q[0]) begin
            n_bad++;
            $display("FAIL result: got sum=%h cout=%b ovf=%b zero=%b expected sum=%h cout=%b ovf=%b zero=%b",
                     sum, cout, overflow, zero, sb_q[0].sum, sb_q[0].cout, sb_q[0].ovf, sb_q[0].zero);
          end
          if (out_ready) begin
            void'(sb_q.pop_front());
            n_pop++;
          end
        end
      end
    end
  end

  initial begin
    logic        acc, v, ordy, rc, rs;
    logic [31:0] ra, rb;
    int          cnt, c, i, n_acc, cyc, pops0;

    // reset held with in_valid high
    rst_n = 1'b0; in_valid = 1'b1; a = 32'hFFFFFFFF; b = 32'h1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);
    check("rel_out_valid", 64'(out_valid), 64'd0);

    // carry ripples through every segment; measure latency
    drive(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, '{32'h0, 1'b1, 1'b0, 1'b1}, acc);
    check("carry_accept", 64'(acc), 64'd1);
    cnt = 0;
    do begin
      idle(1);
      cnt++;
    end while (!out_valid && cnt < 20);
    check("latency_edges", 64'(cnt - 1), 64'(NSEG - 1));
    idle(2);

    // subtract corners and carry/borrow-in
    drive(1'b1, 32'h80000000, 32'h1, 1'b0, 1'b1, 1'b1, '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0}, acc);
    drive(1'b1, 32'd5, 32'd7, 1'b0, 1'b1, 1'b1, '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b0}, acc);
    drive(1'b1, 32'd10, 32'd3, 1'b1, 1'b1, 1'b1, '{32'd6, 1'b1, 1'b0, 1'b0}, acc);
    drive(1'b1, 32'h7FFFFFFF, 32'h0, 1'b1, 1'b0, 1'b1, '{32'h80000000, 1'b0, 1'b1, 1'b0}, acc);
    drive(1'b1, 32'h1234ABCD, 32'h1234ABCD, 1'b0, 1'b1, 1'b1, '{32'h0, 1'b1, 1'b0, 1'b1}, acc);
    drain(20);

    // backpressure: out_ready low during stream cycles 5..9
    pops0 = n_pop;
    i = 0;
    c = 0;
    while (i < 8 && c < 100) begin
      ordy = !(c >= 5 && c <= 9);
      drive(1'b1, 32'(i), 32'h00FFFFFF, 1'b0, 1'b0, ordy,
            '{32'h00FFFFFF + 32'(i), 1'b0, 1'b0, 1'b0}, acc);
      if (c == 7) check("stall_in_ready", 64'(in_ready), 64'd0);
      if (acc) i++;
      c++;
    end
    drain(30);
    check("bp_delivered", 64'(n_pop - pops0), 64'd8);

    // reset with beats in flight
    for (int k = 0; k < 3; k++)
      drive(1'b1, 32'(k + 1), 32'd100, 1'b0, 1'b0, 1'b1, ref_model(32'(k + 1), 32'd100, 1'b0, 1'b0), acc);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      idle(1);
      check("post_reset_idle", 64'(out_valid), 64'd0);
    end
    pops0 = n_pop;
    drive(1'b1, 32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b1, '{32'h23456789, 1'b0, 1'b0, 1'b0}, acc);
    drain(20);
    check("post_reset_beat", 64'(n_pop - pops0), 64'd1);

    // random traffic with random backpressure
    n_acc = 0;
    cyc = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0: ra = 32'h00000000;
        1: ra = 32'hFFFFFFFF;
        2: ra = 32'h80000000;
        3: ra = 32'h7FFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'h00000000;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'h80000000;
        3: rb = ra;
        default: rb = $urandom;
      endcase
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      drive(v, ra, rb, rc, rs, ordy, ref_model(ra, rb, rc, rs), acc);
      if (acc) n_acc++;
      cyc++;
    end
    check("random_accepted", 64'(n_acc), 64'd10000);
    drain(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
